// File: rtl/mem_arbiter_pkg.sv
// Shared types and default widths for the memory request arbiter.
package mem_arbiter_pkg;

   localparam int MEM_ADDR_W      = 42;
   localparam int MEM_DATA_W      = 512;
   localparam int DEF_NUM_CLIENTS = 2;
   localparam int CLIENT_ID_W     = $clog2(DEF_NUM_CLIENTS);

   typedef logic [CLIENT_ID_W-1:0] t_client_id;

   typedef struct packed {
      logic                  write;
      logic [MEM_ADDR_W-1:0] addr;
      logic [MEM_DATA_W-1:0] data;
   } t_arb_req;

   // Client id width; never below one bit.
   function automatic int id_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/mem_arbiter_id_fifo.sv
// Synchronous FIFO of client ids; push and pop may coincide at any fill
// level, including full and empty (count then stays the same).
module id_fifo #(
   parameter int W     = 1,
   parameter int DEPTH = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         push,
   input  logic [W-1:0] push_data,
   input  logic         pop,
   output logic [W-1:0] pop_data,
   output logic         full,
   output logic         empty
);

   localparam int AW = $clog2(DEPTH);

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [AW:0]   count;

   assign pop_data = mem[rd_ptr];
   assign full     = (count == (AW+1)'(DEPTH));
   assign empty    = (count == '0);

   // Storage: a write at full lands on the slot being popped; the pop sees the old value.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= push_data;
   end

   // Pointers wrap naturally (power-of-two depth); count tracks fill level.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({push, pop})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin front end: N clients share one registered memory request slot;
// in-order memory responses are routed back through a FIFO of issuing ids.
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int NUM_CLIENTS     = DEF_NUM_CLIENTS,
   parameter int ADDR_W          = MEM_ADDR_W,
   parameter int DATA_W          = MEM_DATA_W,
   parameter int MAX_OUTSTANDING = 8
) (
   input  logic                                clk,
   input  logic                                rst_n,
   input  logic                                buffer_addr_valid,
   input  logic [NUM_CLIENTS-1:0]              cl_req_valid,
   output logic [NUM_CLIENTS-1:0]              cl_req_ready,
   input  logic [NUM_CLIENTS-1:0]              cl_req_write,
   input  logic [NUM_CLIENTS-1:0][ADDR_W-1:0]  cl_req_addr,
   input  logic [NUM_CLIENTS-1:0][DATA_W-1:0]  cl_req_data,
   output logic [NUM_CLIENTS-1:0]              cl_rsp_valid,
   output logic [DATA_W-1:0]                   cl_rsp_data,
   output logic                                mem_req_valid,
   input  logic                                mem_req_ready,
   output logic                                mem_req_write,
   output logic [ADDR_W-1:0]                   mem_req_addr,
   output logic [DATA_W-1:0]                   mem_req_data,
   input  logic                                mem_rsp_valid,
   input  logic [DATA_W-1:0]                   mem_rsp_data,
   output logic                                err_unexpected_rsp
);

   localparam int ID_W = id_width(NUM_CLIENTS);

   typedef struct packed {
      logic              write;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
   } req_t;

   req_t            slot;
   logic [ID_W-1:0] rr, winner, hi, lo, head_id, rsp_id;
   logic            found_hi, fifo_full, fifo_empty, load, pop;

   // Winner: lowest valid client at or above rr, else lowest valid overall (wrap).
   always_comb begin
      hi       = '0;
      lo       = '0;
      found_hi = 1'b0;
      for (int i = NUM_CLIENTS-1; i >= 0; i--) begin
         if (cl_req_valid[i]) begin
            lo = ID_W'(i);
            if (ID_W'(i) >= rr) begin
               hi       = ID_W'(i);
               found_hi = 1'b1;
            end
         end
      end
      winner = found_hi ? hi : lo;
   end

   // A same-cycle response frees a FIFO entry, so a full FIFO may still grant.
   assign load = rst_n & buffer_addr_valid & (~mem_req_valid | mem_req_ready)
               & (~fifo_full | mem_rsp_valid) & (|cl_req_valid);

   // Response to an empty FIFO is only legal if this cycle's grant supplies the id.
   assign pop    = mem_rsp_valid & (~fifo_empty | load);
   assign rsp_id = fifo_empty ? winner : head_id;

   // One-hot accept to the winner, only in a load cycle.
   always_comb begin
      cl_req_ready = '0;
      if (load) cl_req_ready[winner] = 1'b1;
   end

   // Round-robin pointer moves past the winner on every grant.
   always_ff @(posedge clk) begin
      if (!rst_n)    rr <= '0;
      else if (load) rr <= (winner == ID_W'(NUM_CLIENTS-1)) ? '0 : winner + ID_W'(1);
   end

   // Request slot: loads on grant, holds stable until memory accepts.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         mem_req_valid <= 1'b0;
         slot          <= '0;
      end else if (load) begin
         mem_req_valid <= 1'b1;
         slot          <= '{write: cl_req_write[winner],
                            addr:  cl_req_addr[winner],
                            data:  cl_req_data[winner]};
      end else if (mem_req_ready) begin
         mem_req_valid <= 1'b0;
      end
   end

   assign mem_req_write = slot.write;
   assign mem_req_addr  = slot.addr;
   assign mem_req_data  = slot.data;

   // Response routing one cycle after memory; orphan responses set the sticky error.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cl_rsp_valid       <= '0;
         cl_rsp_data        <= '0;
         err_unexpected_rsp <= 1'b0;
      end else begin
         cl_rsp_valid <= '0;
         if (pop) cl_rsp_valid[rsp_id] <= 1'b1;
         cl_rsp_data        <= mem_rsp_data;
         err_unexpected_rsp <= err_unexpected_rsp | (mem_rsp_valid & ~pop);
      end
   end

   id_fifo #(
      .W     (ID_W),
      .DEPTH (MAX_OUTSTANDING)
   ) u_id_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (load),
      .push_data (winner),
      .pop       (pop),
      .pop_data  (head_id),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

endmodule
